frame_reader: RTL and testbench

FRAME_READER -- requirements
Module: frame_reader

---
 rtl/frame_pkg.sv | 20 ++
 rtl/frame_reader.sv | 123 ++++++++++++
 tb/tb_frame_reader.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_pkg.sv
// Shared definitions for the SDRAM frame reader: FSM state encoding and
// default parameter values.
package frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        REQ,
        DATA,
        DONE
    } frame_state_t;

    localparam int              DEF_ADDR_W      = 24;
    localparam int              DEF_DATA_W      = 16;
    localparam longint unsigned DEF_FRAME_BASE  = 64'd0;
    localparam int              DEF_FRAME_WORDS = 307200;
    localparam int              DEF_BURST_LEN   = 256;
    localparam int              DEF_FIFO_DEPTH  = 1024;

endpackage

// File: rtl/frame_reader.sv
// Reads one frame from SDRAM as a series of bursts, throttled by downstream
// FIFO space, and forwards each returned word to the FIFO one cycle later.
module frame_reader
    import frame_pkg::*;
#(
    parameter int              ADDR_W      = DEF_ADDR_W,
    parameter int              DATA_W      = DEF_DATA_W,
    parameter longint unsigned FRAME_BASE  = DEF_FRAME_BASE,
    parameter int              FRAME_WORDS = DEF_FRAME_WORDS,
    parameter int              BURST_LEN   = DEF_BURST_LEN,
    parameter int              FIFO_DEPTH  = DEF_FIFO_DEPTH
)(
    input  logic                          mem_clk,
    input  logic                          rst_n,
    input  logic                          frame_start,
    input  logic [$clog2(FIFO_DEPTH):0]   fifo_wrusedw,
    output logic                          rd_req,
    output logic [ADDR_W-1:0]             rd_addr,
    output logic [$clog2(BURST_LEN):0]    rd_len,
    input  logic                          rd_ack,
    input  logic                          rd_data_valid,
    input  logic [DATA_W-1:0]             rd_data,
    output logic                          fifo_wr_en,
    output logic [DATA_W-1:0]             fifo_wr_data,
    output logic                          read_finish,
    output logic                          busy
);

    localparam int     LEN_W      = $clog2(BURST_LEN) + 1;
    localparam int     REM_W      = $clog2(FRAME_WORDS + 1);
    localparam longint FILL_LIMIT = longint'(FIFO_DEPTH) - longint'(BURST_LEN);

    frame_state_t     state;
    frame_state_t     state_next;
    logic [REM_W-1:0] remaining;
    logic [LEN_W-1:0] beat_cnt;
    logic             fifo_room;
    logic             beat_in;
    logic             last_beat;
    logic             frame_end;

    // A burst is only issued when the FIFO can absorb a full-length burst.
    assign fifo_room = longint'(fifo_wrusedw) <= FILL_LIMIT;
    assign beat_in   = (state == DATA) && rd_data_valid;
    assign last_beat = beat_in && ((beat_cnt + LEN_W'(1)) == rd_len);
    assign frame_end = longint'(remaining) == longint'(rd_len);

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (frame_start) state_next = CHECK;
            CHECK:   if (fifo_room) state_next = REQ;
            REQ:     if (rd_ack) state_next = DATA;
            DATA:    if (last_beat) state_next = frame_end ? DONE : CHECK;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rd_req      = (state == REQ);
        busy        = (state != IDLE);
        read_finish = (state == DONE);
    end

    // rd_addr doubles as the running frame address; it only moves once a
    // burst has fully returned, so it stays stable while rd_req is held.
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr   <= '0;
            rd_len    <= '0;
            remaining <= '0;
            beat_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        rd_addr   <= ADDR_W'(FRAME_BASE);
                        remaining <= REM_W'(FRAME_WORDS);
                    end
                end
                CHECK: begin
                    if (fifo_room) begin
                        rd_len   <= (longint'(remaining) >= longint'(BURST_LEN)) ?
                                    LEN_W'(BURST_LEN) : LEN_W'(remaining);
                        beat_cnt <= '0;
                    end
                end
                DATA: begin
                    if (rd_data_valid) begin
                        beat_cnt <= beat_cnt + LEN_W'(1);
                        if (last_beat) begin
                            remaining <= remaining - REM_W'(rd_len);
                            rd_addr   <= rd_addr + ADDR_W'(rd_len);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
        end else begin
            fifo_wr_en <= beat_in;
            if (beat_in) begin
                fifo_wr_data <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_frame_reader.sv
// Randomized self-checking bench for frame_reader; two instances cover the
// zero-based frame and the address-wrapping frame.
module tb_frame_reader;

    localparam int              ADDR_W    = 24;
    localparam int              DATA_W    = 16;
    localparam int              BURST_LEN = 256;
    localparam int              WORDS_A   = 600;
    localparam int              WORDS_B   = 300;
    localparam longint unsigned BASE_A    = 64'd0;
    localparam longint unsigned BASE_B    = 64'd16777116;

    logic              mem_clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              frame_start = 1'b0;
    logic              rd_ack = 1'b0;
    logic              rd_data_valid = 1'b0;
    logic [DATA_W-1:0] rd_data = '0;
    logic [10:0]       fifo_wrusedw = '0;
    logic              sel = 1'b0;

    logic              frame_start_a, frame_start_b, rd_ack_a, rd_ack_b;
    logic              rd_req_a, rd_req_b, fifo_wr_en_a, fifo_wr_en_b;
    logic              read_finish_a, read_finish_b, busy_a, busy_b;
    logic [ADDR_W-1:0] rd_addr_a, rd_addr_b;
    logic [8:0]        rd_len_a, rd_len_b;
    logic [DATA_W-1:0] fifo_wr_data_a, fifo_wr_data_b;

    logic              cur_rd_req, cur_fifo_wr_en, cur_read_finish, cur_busy;
    logic [ADDR_W-1:0] cur_rd_addr;
    logic [8:0]        cur_rd_len;
    logic [DATA_W-1:0] cur_fifo_wr_data;

    int checks = 0;
    int errors = 0;
    int fin_cnt = 0;
    int unstable = 0;
    int lat_err = 0;
    int timeouts = 0;
    int ack_err = 0;
    int hi_min, hi_max;
    logic              prev_req = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [8:0]        prev_len = '0;

    logic [ADDR_W-1:0] exp_addr_q[$];
    int                exp_len_q[$];
    logic [ADDR_W-1:0] obs_addr_q[$];
    int                obs_len_q[$];
    logic [DATA_W-1:0] obs_data_q[$];
    logic [DATA_W-1:0] sent_q[$];

    always #5 mem_clk = ~mem_clk;

    assign frame_start_a = frame_start & ~sel;
    assign frame_start_b = frame_start & sel;
    assign rd_ack_a      = rd_ack & ~sel;
    assign rd_ack_b      = rd_ack & sel;

    assign cur_rd_req       = sel ? rd_req_b       : rd_req_a;
    assign cur_rd_addr      = sel ? rd_addr_b      : rd_addr_a;
    assign cur_rd_len       = sel ? rd_len_b       : rd_len_a;
    assign cur_fifo_wr_en   = sel ? fifo_wr_en_b   : fifo_wr_en_a;
    assign cur_fifo_wr_data = sel ? fifo_wr_data_b : fifo_wr_data_a;
    assign cur_read_finish  = sel ? read_finish_b  : read_finish_a;
    assign cur_busy         = sel ? busy_b         : busy_a;

    frame_reader #(.FRAME_BASE(BASE_A), .FRAME_WORDS(WORDS_A)) dut_a (
        .mem_clk(mem_clk), .rst_n(rst_n), .frame_start(frame_start_a),
        .fifo_wrusedw(fifo_wrusedw), .rd_req(rd_req_a), .rd_addr(rd_addr_a),
        .rd_len(rd_len_a), .rd_ack(rd_ack_a), .rd_data_valid(rd_data_valid),
        .rd_data(rd_data), .fifo_wr_en(fifo_wr_en_a), .fifo_wr_data(fifo_wr_data_a),
        .read_finish(read_finish_a), .busy(busy_a)
    );

    frame_reader #(.FRAME_BASE(BASE_B), .FRAME_WORDS(WORDS_B)) dut_b (
        .mem_clk(mem_clk), .rst_n(rst_n), .frame_start(frame_start_b),
        .fifo_wrusedw(fifo_wrusedw), .rd_req(rd_req_b), .rd_addr(rd_addr_b),
        .rd_len(rd_len_b), .rd_ack(rd_ack_b), .rd_data_valid(rd_data_valid),
        .rd_data(rd_data), .fifo_wr_en(fifo_wr_en_b), .fifo_wr_data(fifo_wr_data_b),
        .read_finish(read_finish_b), .busy(busy_b)
    );

    // Mid-cycle observer: records accepted bursts, FIFO writes, finish pulses
    // and any change of rd_addr/rd_len while a request is pending.
    always @(negedge mem_clk) begin
        if (cur_rd_req && prev_req && (cur_rd_addr != prev_addr || cur_rd_len != prev_len))
            unstable++;
        if (cur_rd_req && rd_ack) begin
            obs_addr_q.push_back(cur_rd_addr);
            obs_len_q.push_back(int'(cur_rd_len));
        end
        if (cur_fifo_wr_en) obs_data_q.push_back(cur_fifo_wr_data);
        if (cur_read_finish) fin_cnt++;
        prev_req  = cur_rd_req;
        prev_addr = cur_rd_addr;
        prev_len  = cur_rd_len;
    end

    task automatic tick;
        @(posedge mem_clk);
        #1;
    endtask

    task automatic pulse_start;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic clear_obs;
        obs_addr_q.delete();
        obs_len_q.delete();
        obs_data_q.delete();
        sent_q.delete();
        fin_cnt  = 0;
        unstable = 0;
        lat_err  = 0;
        timeouts = 0;
        ack_err  = 0;
        hi_min   = 1000;
        hi_max   = -1;
    endtask

    // Reference: a frame is cut into min(BURST_LEN, remaining)-word bursts at
    // consecutive addresses modulo 2^ADDR_W.
    task automatic build_model(input longint unsigned base, input int words);
        longint unsigned off;
        int rem, len;
        off = 0;
        rem = words;
        exp_addr_q.delete();
        exp_len_q.delete();
        while (rem > 0) begin
            len = (rem < BURST_LEN) ? rem : BURST_LEN;
            exp_addr_q.push_back(ADDR_W'((base + off) % (64'd1 << ADDR_W)));
            exp_len_q.push_back(len);
            off += longint'(len);
            rem -= len;
        end
    endtask

    // Plays the SDRAM controller for one whole frame; records observations
    // for the calling test to compare.
    task automatic serve_frame(input int ack_delay, input int max_gap, input bit poke);
        int waited, dly, hi, len, sent;
        bit done, v, poked;
        logic [DATA_W-1:0] d;
        done  = 0;
        poked = 0;
        while (!done) begin
            waited = 0;
            while (!cur_rd_req && !cur_read_finish && waited < 3000) begin
                tick();
                waited++;
            end
            if (waited >= 3000) begin
                timeouts++;
                done = 1;
            end else if (cur_read_finish) begin
                if (poke) begin
                    frame_start = 1'b1;
                    tick();
                    frame_start = 1'b0;
                end
                done = 1;
            end else begin
                dly = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
                hi  = 0;
                repeat (dly) begin
                    if (cur_rd_req) hi++;
                    rd_data_valid = poke;
                    rd_data = DATA_W'($urandom);
                    tick();
                end
                if (hi < hi_min) hi_min = hi;
                if (hi > hi_max) hi_max = hi;
                rd_data_valid = 1'b0;
                len    = int'(cur_rd_len);
                rd_ack = 1'b1;
                tick();
                rd_ack = 1'b0;
                if (cur_rd_req) ack_err++;
                sent = 0;
                while (sent < len) begin
                    v = ($urandom_range(0, max_gap) == 0);
                    d = DATA_W'($urandom);
                    rd_data_valid = v;
                    rd_data = d;
                    if (v) begin
                        sent_q.push_back(d);
                        sent++;
                    end
                    if (poke && !poked && sent == len / 2) begin
                        frame_start = 1'b1;
                        poked = 1;
                    end
                    tick();
                    frame_start = 1'b0;
                    if (cur_fifo_wr_en !== v || (v && cur_fifo_wr_data !== d)) lat_err++;
                end
                rd_data_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) tick();
        checks++; if (rd_req_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_req: got %b expected 0", rd_req_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_a); end
        checks++; if (fifo_wr_en_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_en: got %b expected 0", fifo_wr_en_a); end
        checks++; if (read_finish_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_finish: got %b expected 0", read_finish_a); end
        checks++; if ({rd_addr_a, rd_len_a, fifo_wr_data_a} !== '0) begin errors++; $display("[TB] FAIL reset_regs: got %h/%h/%h expected 0", rd_addr_a, rd_len_a, fifo_wr_data_a); end
        checks++; if ({rd_addr_b, rd_len_b, busy_b, rd_req_b} !== '0) begin errors++; $display("[TB] FAIL reset_wrap_inst: got %h/%h/%b/%b expected 0", rd_addr_b, rd_len_b, busy_b, rd_req_b); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_frame;
        int mism;
        sel = 1'b0;
        fifo_wrusedw = '0;
        clear_obs();
        build_model(BASE_A, WORDS_A);
        pulse_start();
        serve_frame(-1, 2, 0);
        repeat (3) tick();
        checks++; if (timeouts !== 0) begin errors++; $display("[TB] FAIL basic_timeout: got %0d expected 0", timeouts); end
        checks++;
        if (obs_addr_q.size() !== exp_addr_q.size()) begin
            errors++; $display("[TB] FAIL basic_burst_count: got %0d expected %0d", obs_addr_q.size(), exp_addr_q.size());
        end else begin
            for (int i = 0; i < exp_addr_q.size(); i++) begin
                checks++; if (obs_addr_q[i] !== exp_addr_q[i]) begin errors++; $display("[TB] FAIL basic_addr[%0d]: got %0d expected %0d", i, obs_addr_q[i], exp_addr_q[i]); end
                checks++; if (obs_len_q[i] !== exp_len_q[i]) begin errors++; $display("[TB] FAIL basic_len[%0d]: got %0d expected %0d", i, obs_len_q[i], exp_len_q[i]); end
            end
        end
        checks++;
        if (obs_data_q.size() !== WORDS_A) begin
            errors++; $display("[TB] FAIL basic_write_count: got %0d expected %0d", obs_data_q.size(), WORDS_A);
        end else if (sent_q.size() == WORDS_A) begin
            mism = 0;
            for (int i = 0; i < WORDS_A; i++) if (obs_data_q[i] !== sent_q[i]) mism++;
            checks++; if (mism !== 0) begin errors++; $display("[TB] FAIL basic_write_data: got %0d bad words expected 0", mism); end
        end
        checks++; if (lat_err !== 0) begin errors++; $display("[TB] FAIL basic_write_latency: got %0d late/wrong writes expected 0", lat_err); end
        checks++; if (fin_cnt !== 1) begin errors++; $display("[TB] FAIL basic_finish: got %0d pulses expected 1", fin_cnt); end
        checks++; if (ack_err !== 0) begin errors++; $display("[TB] FAIL basic_req_drop: got %0d expected 0", ack_err); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle: got busy %b expected 0", busy_a); end
    endtask

    task automatic test_flow_control;
        int seen, waited;
        sel = 1'b0;
        clear_obs();
        build_model(BASE_A, WORDS_A);
        fifo_wrusedw = 11'd900;
        pulse_start();
        seen = 0;
        repeat (30) begin if (cur_rd_req) seen++; tick(); end
        checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL flow_full_req: got %0d req cycles expected 0", seen); end
        checks++; if (busy_a !== 1'b1) begin errors++; $display("[TB] FAIL flow_busy: got %b expected 1", busy_a); end
        fifo_wrusedw = 11'd769;
        repeat (10) begin if (cur_rd_req) seen++; tick(); end
        checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL flow_769_req: got %0d req cycles expected 0", seen); end
        fifo_wrusedw = 11'd768;
        waited = 0;
        while (!cur_rd_req && waited < 20) begin tick(); waited++; end
        checks++; if (waited !== 1) begin errors++; $display("[TB] FAIL flow_req_after_drop: got %0d cycles expected 1", waited); end
        serve_frame(-1, 1, 0);
        repeat (3) tick();
        checks++; if (obs_addr_q.size() !== exp_addr_q.size()) begin errors++; $display("[TB] FAIL flow_burst_count: got %0d expected %0d", obs_addr_q.size(), exp_addr_q.size()); end
        checks++; if (obs_data_q.size() !== WORDS_A) begin errors++; $display("[TB] FAIL flow_write_count: got %0d expected %0d", obs_data_q.size(), WORDS_A); end
        checks++; if (fin_cnt !== 1) begin errors++; $display("[TB] FAIL flow_finish: got %0d expected 1", fin_cnt); end
        fifo_wrusedw = '0;
    endtask

    task automatic test_ack_delay;
        sel = 1'b0;
        clear_obs();
        build_model(BASE_A, WORDS_A);
        pulse_start();
        serve_frame(5, 0, 0);
        repeat (3) tick();
        checks++; if (hi_min !== 5 || hi_max !== 5) begin errors++; $display("[TB] FAIL ack_req_cycles: got %0d..%0d expected 5", hi_min, hi_max); end
        checks++; if (unstable !== 0) begin errors++; $display("[TB] FAIL ack_stable: got %0d changes expected 0", unstable); end
        checks++;
        if (obs_addr_q.size() !== exp_addr_q.size()) begin
            errors++; $display("[TB] FAIL ack_burst_count: got %0d expected %0d", obs_addr_q.size(), exp_addr_q.size());
        end else begin
            for (int i = 0; i < exp_addr_q.size(); i++) begin
                checks++; if (obs_addr_q[i] !== exp_addr_q[i] || obs_len_q[i] !== exp_len_q[i]) begin errors++; $display("[TB] FAIL ack_burst[%0d]: got %0d/%0d expected %0d/%0d", i, obs_addr_q[i], obs_len_q[i], exp_addr_q[i], exp_len_q[i]); end
            end
        end
        checks++; if (fin_cnt !== 1) begin errors++; $display("[TB] FAIL ack_finish: got %0d expected 1", fin_cnt); end
    endtask

    task automatic test_ignored_inputs;
        int mism;
        sel = 1'b0;
        clear_obs();
        build_model(BASE_A, WORDS_A);
        rd_ack = 1'b1;
        rd_data_valid = 1'b1;
        repeat (3) begin rd_data = DATA_W'($urandom); tick(); end
        rd_ack = 1'b0;
        rd_data_valid = 1'b0;
        tick();
        checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL idle_ignore_busy: got %b expected 0", busy_a); end
        checks++; if (obs_data_q.size() !== 0) begin errors++; $display("[TB] FAIL idle_ignore_writes: got %0d expected 0", obs_data_q.size()); end
        pulse_start();
        serve_frame(2, 1, 1);
        repeat (10) tick();
        checks++; if (fin_cnt !== 1) begin errors++; $display("[TB] FAIL restart_finish: got %0d expected 1", fin_cnt); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL restart_idle: got busy %b expected 0", busy_a); end
        checks++; if (obs_addr_q.size() !== exp_addr_q.size()) begin errors++; $display("[TB] FAIL restart_burst_count: got %0d expected %0d", obs_addr_q.size(), exp_addr_q.size()); end
        checks++;
        if (obs_data_q.size() !== sent_q.size()) begin
            errors++; $display("[TB] FAIL stray_beats: got %0d writes expected %0d", obs_data_q.size(), sent_q.size());
        end else begin
            mism = 0;
            for (int i = 0; i < sent_q.size(); i++) if (obs_data_q[i] !== sent_q[i]) mism++;
            checks++; if (mism !== 0) begin errors++; $display("[TB] FAIL stray_data: got %0d bad words expected 0", mism); end
        end
    endtask

    task automatic test_reset_mid;
        int waited;
        sel = 1'b0;
        clear_obs();
        pulse_start();
        for (int b = 0; b < 2; b++) begin
            waited = 0;
            while (!cur_rd_req && waited < 100) begin tick(); waited++; end
            checks++; if (waited >= 100) begin errors++; $display("[TB] FAIL midreset_req_wait: got timeout expected rd_req"); end
            rd_ack = 1'b1;
            tick();
            rd_ack = 1'b0;
            repeat ((b == 0) ? 256 : 40) begin
                rd_data_valid = 1'b1;
                rd_data = DATA_W'($urandom);
                tick();
            end
        end
        checks++; if (rd_addr_a !== 24'd256 || fifo_wr_en_a !== 1'b1) begin errors++; $display("[TB] FAIL midreset_precond: got addr %0d wr_en %b expected 256/1", rd_addr_a, fifo_wr_en_a); end
        rst_n = 1'b0;
        #1;
        checks++; if ({rd_req_a, fifo_wr_en_a, read_finish_a, busy_a} !== 4'b0) begin errors++; $display("[TB] FAIL midreset_flags: got %b expected 0000", {rd_req_a, fifo_wr_en_a, read_finish_a, busy_a}); end
        checks++; if ({rd_addr_a, rd_len_a, fifo_wr_data_a} !== '0) begin errors++; $display("[TB] FAIL midreset_regs: got %h/%h/%h expected 0", rd_addr_a, rd_len_a, fifo_wr_data_a); end
        rd_data_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        checks++; if (fin_cnt !== 0) begin errors++; $display("[TB] FAIL midreset_no_finish: got %0d expected 0", fin_cnt); end
        clear_obs();
        build_model(BASE_A, WORDS_A);
        pulse_start();
        serve_frame(-1, 1, 0);
        repeat (3) tick();
        checks++; if (obs_addr_q.size() == 0 || obs_addr_q[0] !== exp_addr_q[0]) begin errors++; $display("[TB] FAIL midreset_restart_addr: got %0d bursts, first %0d expected base %0d", obs_addr_q.size(), (obs_addr_q.size() == 0) ? 0 : obs_addr_q[0], exp_addr_q[0]); end
        checks++; if (obs_data_q.size() !== WORDS_A || fin_cnt !== 1) begin errors++; $display("[TB] FAIL midreset_restart_frame: got %0d words %0d finish expected %0d/1", obs_data_q.size(), fin_cnt, WORDS_A); end
    endtask

    task automatic test_wrap;
        int mism;
        sel = 1'b1;
        clear_obs();
        build_model(BASE_B, WORDS_B);
        tick();
        pulse_start();
        serve_frame(-1, 2, 0);
        repeat (3) tick();
        checks++;
        if (obs_addr_q.size() !== exp_addr_q.size()) begin
            errors++; $display("[TB] FAIL wrap_burst_count: got %0d expected %0d", obs_addr_q.size(), exp_addr_q.size());
        end else begin
            for (int i = 0; i < exp_addr_q.size(); i++) begin
                checks++; if (obs_addr_q[i] !== exp_addr_q[i]) begin errors++; $display("[TB] FAIL wrap_addr[%0d]: got %0d expected %0d", i, obs_addr_q[i], exp_addr_q[i]); end
                checks++; if (obs_len_q[i] !== exp_len_q[i]) begin errors++; $display("[TB] FAIL wrap_len[%0d]: got %0d expected %0d", i, obs_len_q[i], exp_len_q[i]); end
            end
        end
        checks++;
        if (obs_data_q.size() !== WORDS_B || sent_q.size() !== WORDS_B) begin
            errors++; $display("[TB] FAIL wrap_write_count: got %0d expected %0d", obs_data_q.size(), WORDS_B);
        end else begin
            mism = 0;
            for (int i = 0; i < WORDS_B; i++) if (obs_data_q[i] !== sent_q[i]) mism++;
            checks++; if (mism !== 0) begin errors++; $display("[TB] FAIL wrap_write_data: got %0d bad words expected 0", mism); end
        end
        checks++; if (fin_cnt !== 1) begin errors++; $display("[TB] FAIL wrap_finish: got %0d expected 1", fin_cnt); end
        sel = 1'b0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting frame_reader bench");
        test_reset();
        test_basic_frame();
        test_flow_control();
        test_ack_delay();
        test_ignored_inputs();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
